// File: rtl/apx_add_pkg.sv
// Shared types and helpers for the approximate-adder sharing controller.
package apx_add_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam int NREQ_MAX = 16;

  // Index width for n requesters, never narrower than one bit.
  function automatic int calc_idw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first set request at or after ptr wins.
module rr_arbiter
  import apx_add_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int IDW = calc_idw(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx
);

  int idx;

  // Scan from farthest to nearest so the requester closest to ptr overwrites the others.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    idx       = 0;
    if (en) begin
      for (int k = NREQ - 1; k >= 0; k--) begin
        idx = (int'(ptr) + k) % NREQ;
        if (req[idx]) begin
          grant      = '0;
          grant[idx] = 1'b1;
          grant_idx  = IDW'(idx);
        end
      end
    end
  end

endmodule

// File: rtl/apx_add_share_ctrl.sv
// Shares one approximate adder among NREQ requesters with round-robin grants and a held response.
// Defining APX_ADD_STATS_EN adds the stat_ops / stat_apx_ops completion counters.
module apx_add_share_ctrl
  import apx_add_pkg::*;
#(
  parameter int BWOP    = 32,
  parameter int NREQ    = 4,
  parameter int ADD_LAT = 1,
  localparam int IDW    = calc_idw(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*BWOP-1:0] req_a,
  input  logic [NREQ*BWOP-1:0] req_b,
  input  logic [NREQ-1:0]      req_apx,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [BWOP-1:0]      rsp_c,
  output logic [BWOP-1:0]      add_a,
  output logic [BWOP-1:0]      add_b,
  output logic                 add_apx,
  input  logic [BWOP-1:0]      add_c,
  output logic                 busy
`ifdef APX_ADD_STATS_EN
  ,
  output logic [31:0]          stat_ops,
  output logic [31:0]          stat_apx_ops
`endif
);

  localparam int CW = $clog2(ADD_LAT + 2);

  if (NREQ < 2 || NREQ > NREQ_MAX) begin : g_bad_nreq
    $error("apx_add_share_ctrl: NREQ out of range");
  end

  state_t          state_q, state_d;
  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  grant_idx;
  logic [IDW-1:0]  id_q;
  logic [NREQ-1:0] grant;
  logic [CW-1:0]   counter;
  logic            grant_en;
  logic            granted;

  // A new request may only be taken when the adder is free and no response is stuck.
  assign grant_en  = rst && ((state_q == IDLE) || (state_q == RESP && rsp_ready));
  assign req_ready = grant;
  assign granted   = |grant;
  assign busy      = (state_q != IDLE);

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .en        (grant_en),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (granted) state_d = WAIT;
      WAIT: if (counter == '0) state_d = RESP;
      RESP: if (rsp_ready) state_d = granted ? WAIT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand registers only move on a grant so the adder inputs stay quiet between operations.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr    <= '0;
      id_q      <= '0;
      counter   <= '0;
      add_a     <= '0;
      add_b     <= '0;
      add_apx   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_c     <= '0;
    end else begin
      if (granted) begin
        add_a   <= req_a[grant_idx*BWOP +: BWOP];
        add_b   <= req_b[grant_idx*BWOP +: BWOP];
        add_apx <= req_apx[grant_idx];
        id_q    <= grant_idx;
        counter <= CW'(ADD_LAT);
        rr_ptr  <= (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + 1'b1;
      end else if (state_q == WAIT && counter != '0) begin
        counter <= counter - 1'b1;
      end
      if (state_q == WAIT && counter == '0) begin
        rsp_c     <= add_c;
        rsp_id    <= id_q;
        rsp_valid <= 1'b1;
      end else if (state_q == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

`ifdef APX_ADD_STATS_EN
  // add_apx still holds the completing operation's mode, even if a new grant lands this cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_ops     <= '0;
      stat_apx_ops <= '0;
    end else if (state_q == RESP && rsp_ready) begin
      if (stat_ops != '1) stat_ops <= stat_ops + 1'b1;
      if (add_apx && stat_apx_ops != '1) stat_apx_ops <= stat_apx_ops + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_apx_add_share_ctrl.sv
// Self-checking bench for apx_add_share_ctrl against a transaction-level model.
// Stats checks are active when APX_ADD_STATS_EN is defined.
module tb_apx_add_share_ctrl;

  localparam int BWOP    = 32;
  localparam int NREQ    = 4;
  localparam int ADD_LAT = 1;
  localparam int IDW     = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*BWOP-1:0] req_a;
  logic [NREQ*BWOP-1:0] req_b;
  logic [NREQ-1:0]      req_apx;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic [BWOP-1:0]      rsp_c;
  logic [BWOP-1:0]      add_a;
  logic [BWOP-1:0]      add_b;
  logic                 add_apx;
  logic [BWOP-1:0]      add_c;
  logic                 busy;
`ifdef APX_ADD_STATS_EN
  logic [31:0]          stat_ops;
  logic [31:0]          stat_apx_ops;
`endif

  always #5 clk = ~clk;

  apx_add_share_ctrl #(.BWOP(BWOP), .NREQ(NREQ), .ADD_LAT(ADD_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_apx   (req_apx),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_c     (rsp_c),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_apx   (add_apx),
    .add_c     (add_c),
    .busy      (busy)
`ifdef APX_ADD_STATS_EN
    ,
    .stat_ops     (stat_ops),
    .stat_apx_ops (stat_apx_ops)
`endif
  );

  // Stand-in approximate adder: approximate mode ORs the low nibble instead of adding it.
  function automatic logic [31:0] adder_fn(input logic [31:0] a, input logic [31:0] b, input logic apx);
    logic [31:0] s;
    s = a + b;
    if (apx) s[3:0] = a[3:0] | b[3:0];
    return s;
  endfunction

  always @(posedge clk) add_c <= adder_fn(add_a, add_b, add_apx);

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  // Transaction-level model: one op in flight, then one held response.
  int          ptr;
  bit          op_active;
  int          cycles_left;
  bit          resp_out;
  int          exp_id;
  logic [31:0] exp_a, exp_b, exp_c;
  bit          exp_apx;
  int          exp_ops, exp_apx_ops;
  int          grant_log[$];
  int          grant_cyc[$];
  logic [31:0] a_arr[NREQ];
  logic [31:0] b_arr[NREQ];
  logic [NREQ-1:0] apx_v;

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic resetModel();
    ptr         = 0;
    op_active   = 0;
    cycles_left = 0;
    resp_out    = 0;
    exp_ops     = 0;
    exp_apx_ops = 0;
  endtask

  // Drives one cycle of inputs, checks outputs at the falling edge, then advances the model.
  task automatic applyStimulus(input logic [NREQ-1:0] v, input logic rr);
    logic [NREQ-1:0] exp_ready;
    int g;
    bit window;
    req_valid = v;
    rsp_ready = rr;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*BWOP +: BWOP] = a_arr[i];
      req_b[i*BWOP +: BWOP] = b_arr[i];
      req_apx[i]            = apx_v[i];
    end
    @(negedge clk);
    window = !op_active && (!resp_out || rr);
    g = -1;
    if (window)
      for (int k = 0; k < NREQ; k++)
        if (g < 0 && v[(ptr + k) % NREQ]) g = (ptr + k) % NREQ;
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    checkOutput("req_ready", 64'(req_ready), 64'(exp_ready));
    checkOutput("busy", 64'(busy), 64'(op_active || resp_out));
    checkOutput("rsp_valid", 64'(rsp_valid), 64'(resp_out));
    if (resp_out) begin
      checkOutput("rsp_id", 64'(rsp_id), 64'(exp_id));
      checkOutput("rsp_c", 64'(rsp_c), 64'(exp_c));
    end
    if (op_active || resp_out) begin
      checkOutput("add_a", 64'(add_a), 64'(exp_a));
      checkOutput("add_b", 64'(add_b), 64'(exp_b));
      checkOutput("add_apx", 64'(add_apx), 64'(exp_apx));
    end
`ifdef APX_ADD_STATS_EN
    checkOutput("stat_ops", 64'(stat_ops), 64'(exp_ops));
    checkOutput("stat_apx_ops", 64'(stat_apx_ops), 64'(exp_apx_ops));
`endif
    @(posedge clk);
    if (resp_out && rr) begin
      resp_out = 0;
      exp_ops++;
      if (exp_apx) exp_apx_ops++;
    end
    if (op_active) begin
      cycles_left--;
      if (cycles_left == 0) begin
        op_active = 0;
        resp_out  = 1;
      end
    end else if (g >= 0) begin
      op_active   = 1;
      cycles_left = ADD_LAT + 1;
      exp_id      = g;
      exp_a       = a_arr[g];
      exp_b       = b_arr[g];
      exp_apx     = apx_v[g];
      exp_c       = adder_fn(a_arr[g], b_arr[g], apx_v[g]);
      ptr         = (g + 1) % NREQ;
      grant_log.push_back(g);
      grant_cyc.push_back(cyc);
    end
    cyc++;
    #1;
  endtask

  initial begin
    rst = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    req_a = '0;
    req_b = '0;
    req_apx = '0;
    apx_v = '0;
    for (int i = 0; i < NREQ; i++) begin
      a_arr[i] = '0;
      b_arr[i] = '0;
    end
    resetModel();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_req_ready", 64'(req_ready), 64'h0);
    checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    checkOutput("rst_busy", 64'(busy), 64'h0);
    checkOutput("rst_add_a", 64'(add_a), 64'h0);
    checkOutput("rst_rsp_c", 64'(rsp_c), 64'h0);
    rst = 1'b1;

    // 5 + (-7) on requester 0.
    a_arr[0] = 32'd5;
    b_arr[0] = 32'hFFFF_FFF9;
    applyStimulus(4'b0001, 1'b1);
    applyStimulus(4'b0000, 1'b1);
    applyStimulus(4'b0000, 1'b1);
    checkOutput("t1_rsp_valid", 64'(rsp_valid), 64'h1);
    checkOutput("t1_rsp_c", 64'(rsp_c), 64'hFFFF_FFFE);
    checkOutput("t1_rsp_id", 64'(rsp_id), 64'h0);
    applyStimulus(4'b0000, 1'b1);
    applyStimulus(4'b0000, 1'b1);

    // Overflow operands, exact then approximate.
    a_arr[2] = 32'h7FFF_FFFF;
    b_arr[2] = 32'h1;
    applyStimulus(4'b0100, 1'b1);
    applyStimulus(4'b0000, 1'b1);
    applyStimulus(4'b0000, 1'b1);
    checkOutput("ovf_exact_c", 64'(rsp_c), 64'h8000_0000);
    applyStimulus(4'b0000, 1'b1);
    apx_v = 4'b0100;
    applyStimulus(4'b0100, 1'b1);
    checkOutput("ovf_add_apx", 64'(add_apx), 64'h1);
    applyStimulus(4'b0000, 1'b1);
    applyStimulus(4'b0000, 1'b1);
    checkOutput("ovf_apx_c", 64'(rsp_c), 64'h8000_000F);
    applyStimulus(4'b0000, 1'b1);
    apx_v = '0;

    // Hold the response for 10 cycles with requests pending, then release.
    a_arr[0] = 32'h1234_5678; b_arr[0] = 32'h1111_1111;
    a_arr[1] = 32'hDEAD_0000; b_arr[1] = 32'h0000_BEEF;
    applyStimulus(4'b0001, 1'b1);
    applyStimulus(4'b0000, 1'b1);
    applyStimulus(4'b0000, 1'b1);
    repeat (10) applyStimulus(4'b0110, 1'b0);
    applyStimulus(4'b0110, 1'b1);
    checkOutput("stall_release_grant", 64'(grant_log[$]), 64'h1);
    repeat (4) applyStimulus(4'b0000, 1'b1);

    // Reset while the adder is busy.
    applyStimulus(4'b0001, 1'b1);
    rst = 1'b0;
    #1;
    checkOutput("midrst_busy", 64'(busy), 64'h0);
    checkOutput("midrst_req_ready", 64'(req_ready), 64'h0);
    checkOutput("midrst_add_a", 64'(add_a), 64'h0);
    checkOutput("midrst_add_b", 64'(add_b), 64'h0);
    checkOutput("midrst_add_apx", 64'(add_apx), 64'h0);
    checkOutput("midrst_rsp", 64'({rsp_valid, rsp_id, rsp_c}), 64'h0);
    resetModel();
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (5) applyStimulus(4'b0000, 1'b1);

    // All four requesting: rotation 0,1,2,3,0 with one grant every 3 cycles.
    grant_log.delete();
    grant_cyc.delete();
    for (int i = 0; i < NREQ; i++) begin
      a_arr[i] = 32'h100 * (i + 1);
      b_arr[i] = 32'h11 * (i + 3);
    end
    apx_v = 4'b1010;
    repeat (15) applyStimulus(4'b1111, 1'b1);
    checkOutput("rr_count", 64'(grant_log.size() >= 5), 64'h1);
    if (grant_log.size() >= 5) begin
      checkOutput("rr_g0", 64'(grant_log[0]), 64'd0);
      checkOutput("rr_g1", 64'(grant_log[1]), 64'd1);
      checkOutput("rr_g2", 64'(grant_log[2]), 64'd2);
      checkOutput("rr_g3", 64'(grant_log[3]), 64'd3);
      checkOutput("rr_g4", 64'(grant_log[4]), 64'd0);
      for (int i = 0; i < 4; i++)
        checkOutput("rr_spacing", 64'(grant_cyc[i+1] - grant_cyc[i]), 64'd3);
    end
    repeat (4) applyStimulus(4'b0000, 1'b1);
`ifdef APX_ADD_STATS_EN
    checkOutput("stats_ops5", 64'(stat_ops), 64'd5);
    checkOutput("stats_apx2", 64'(stat_apx_ops), 64'd2);
`endif

    // Random traffic with a randomly stalling consumer.
    repeat (400) begin
      for (int i = 0; i < NREQ; i++) begin
        a_arr[i] = $urandom;
        b_arr[i] = $urandom;
      end
      apx_v = NREQ'($urandom);
      applyStimulus(NREQ'($urandom), ($urandom_range(0, 3) != 0));
    end
    repeat (6) applyStimulus(4'b0000, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/apx_add_share_ctrl.md
Name: apx_add_share_ctrl

Overview:
- Shares one external approximate integer adder between NREQ requesters.
- Uses round-robin arbitration and a valid/ready request interface.
- Sequences each operation: captures the operands, drives the adder, waits ADD_LAT cycles, then returns the sum and the requester ID on a buffered response port.
- Sits between the integer-op clients and a single `unconfig_int_add`-class instance. It also drives that adder's approximation control.

Parameters:
- BWOP, 32, operand and result bit width.
- NREQ, 4, number of requesters (2..16).
- ADD_LAT, 1, cycles from add_a/add_b being driven to add_c being valid (0 = combinational adder).
- IDW, derived localparam, clog2(NREQ), minimum 1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_a  in  NREQ*BWOP  operand A; requester i uses bits [i*BWOP +: BWOP].
- req_b  in  NREQ*BWOP  operand B; same slicing as req_a.
- req_apx  in  NREQ  per-requester approximation enable.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  IDW  index of the requester being answered.
- rsp_c  out  BWOP  sum.
- add_a  out  BWOP  operand A to the shared adder.
- add_b  out  BWOP  operand B to the shared adder.
- add_apx  out  1  approximation control to the adder.
- add_c  in  BWOP  adder result.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, rr_ptr=0, counter=0.
  - rsp_valid=0, rsp_id=0, rsp_c=0, add_a=0, add_b=0, add_apx=0, busy=0.
  - req_ready=0 (combinational, forced to 0 while in reset).
- Reset mid-operation: the in-flight operation is dropped and no response is issued.
- States: IDLE, WAIT, RESP.
- Grant window: only in IDLE, or in RESP in the same cycle that rsp_ready=1.
- Arbitration:
  - Round-robin search starts at rr_ptr over req_valid; first set bit is g.
  - req_ready[g]=1 combinationally; all other req_ready bits are 0.
  - Handshake occurs when req_valid[g] & req_ready[g].
  - After a grant, rr_ptr <= (g+1) mod NREQ. rr_ptr is unchanged when there is no grant.
- On a grant:
  - add_a, add_b and add_apx are registered from slice g of req_a, req_b and req_apx.
  - id_q <= g.
  - counter <= ADD_LAT.
  - state <= WAIT.
- add_* registers change only on a grant, and hold their value otherwise (no toggling when idle).
- WAIT:
  - If counter != 0, decrement it.
  - If counter == 0: rsp_c <= add_c, rsp_id <= id_q, rsp_valid <= 1, state <= RESP.
  - WAIT therefore lasts ADD_LAT+1 cycles.
- RESP:
  - rsp_valid, rsp_id and rsp_c are held stable until rsp_ready=1.
  - On rsp_ready=1, rsp_valid is cleared. State goes to WAIT if a grant occurs in that same cycle, otherwise to IDLE.
- Latency: handshake in cycle T gives rsp_valid=1 in cycle T+ADD_LAT+2.
- Throughput: with rsp_ready held at 1, one operation completes per ADD_LAT+2 cycles.
- Arithmetic: the block does no arithmetic. rsp_c is add_c copied verbatim (two's complement, wraps at BWOP bits).
- Boundary conditions:
  - A requester deasserting req_valid without a handshake is legal; arbitration simply re-evaluates.
  - Only one operation is in flight at a time, so no response can overflow.

Optional Feature:
- Macro: APX_ADD_STATS_EN.
- When defined, adds two outputs:
  - stat_ops (32 bits): total completed responses (RESP & rsp_ready).
  - stat_apx_ops (32 bits): completed responses whose add_apx was 1.
- Both counters saturate at 0xFFFFFFFF and reset to 0.
- When not defined, the ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Package apx_add_pkg holds:
  - the state enum (IDLE, WAIT, RESP);
  - localparam NREQ_MAX=16;
  - the clog2-based IDW helper function.
- One sub-module, rr_arbiter:
  - parameter NREQ;
  - inputs: req vector, ptr, en;
  - outputs: one-hot grant and encoded index.
  - purely combinational.
- The pointer register lives in the parent.

Test Plan (NREQ=4, ADD_LAT=1, BWOP=32):
- Reset, then req_valid=4'b0001, a=5, b=-7, apx=0, rsp_ready=1:
  - req_ready=4'b0001 in cycle T;
  - rsp_valid=1 at T+3 with rsp_c=-2, rsp_id=0;
  - busy falls after the response.
- All four req_valid held high with distinct operands:
  - grants go in order 0,1,2,3,0;
  - rsp_id follows the same order;
  - one response every 3 cycles.
- rsp_ready=0 for 10 cycles while in RESP:
  - rsp_valid, rsp_id and rsp_c stay stable;
  - no req_ready is asserted;
  - releasing rsp_ready with a pending request grants in that same cycle.
- Operands a=0x7FFFFFFF, b=1, apx=1:
  - add_apx=1 during WAIT;
  - rsp_c equals the adder output exactly (0x80000000 for exact mode).
- Assert rst=0 during WAIT:
  - all outputs are 0 immediately;
  - no response after release;
  - the next grant goes to requester 0.
- APX_ADD_STATS_EN defined, 3 exact and 2 approximate ops:
  - stat_ops=5, stat_apx_ops=2.
